mac_div_seq: RTL and testbench

- Sequential restoring divider. It is the inverse-arithmetic companion to the registered adder/MAC datapath.
- Takes an unsigned dividend/divisor pair on a start handshake and iterates one quotient bit per enabled clock.
- Presents registered quotient/remainder with a one-cycle done pulse.
- Used downstream of the MAC_512 accumulator to normalise/scale accumulated results.

---
 rtl/mac_div_seq_if.sv | 24 ++
 rtl/mac_div_seq.sv | 106 ++++++++++
 tb/tb_mac_div_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_div_seq_if.sv
// Divider request/result bundle: master drives operands and start, slave returns results.
interface mac_div_seq_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output en, start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  en, start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mac_div_seq.sv
// Restoring unsigned divider, one quotient bit per enabled edge; done 1 cycle after the last step (immediately on /0).
// No backpressure: start is only taken in IDLE, and en=0 freezes every register including done.
module mac_div_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_div_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  // Partial remainder stays below the divisor, so its top (sign) bit is always 0 and is not stored.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remd;
  logic             r_dbz;

  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_t;
  logic             w_neg;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_s       = {r_rem, r_q[WIDTH-1]};
  assign w_t       = w_s + {1'b1, ~r_d} + (WIDTH+1)'(1);
  assign w_neg     = w_t[WIDTH];
  assign w_rem_nxt = w_neg ? w_s[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_neg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_dbz   <= 1'b0;
    end else if (bus.en) begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_q    <= bus.dividend;
            r_d    <= bus.divisor;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (bus.divisor == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_remd  <= bus.dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q   <= w_q_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_quot  <= w_q_nxt;
            r_remd  <= w_rem_nxt;
            r_dbz   <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_mac_div_seq.sv
// Directed vector table plus stall, ignored-start, async-reset and randomised invariant sequences.
module tb_mac_div_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_div_seq_if #(.WIDTH(W)) dif();
  mac_div_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // lat counts edges from the accepting edge (inclusive) until done is seen high.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                         output logic done_after, output logic busy_after);
    dif.dividend = a;
    dif.divisor  = b;
    dif.start    = 1'b1;
    lat  = 0;
    bcnt = 0;
    do begin
      @(posedge clk);
      #1;
      dif.start    = 1'b0;
      dif.dividend = ~a;
      dif.divisor  = ~b;
      lat++;
      if (dif.busy) bcnt++;
    end while (!dif.done && lat < 100);
    q = dif.quotient;
    r = dif.remainder;
    z = dif.div_by_zero;
    @(posedge clk);
    #1;
    done_after = dif.done;
    busy_after = dif.busy;
  endtask

  int           lat, bcnt, nd;
  logic [W-1:0] q, r, a, b;
  logic         z, dna, bza;
  logic [31:0]  prod;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'd100,    16'd7,      16'd14,     16'd2,      1'b0};
    vecs[1]  = '{16'hFFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0};
    vecs[2]  = '{16'd0,      16'd5,      16'd0,      16'd0,      1'b0};
    vecs[3]  = '{16'd5,      16'hFFFF,   16'd0,      16'd5,      1'b0};
    vecs[4]  = '{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,      1'b0};
    vecs[5]  = '{16'h1234,   16'd0,      16'hFFFF,   16'h1234,   1'b1};
    vecs[6]  = '{16'd7,      16'd100,    16'd0,      16'd7,      1'b0};
    vecs[7]  = '{16'd65535,  16'd256,    16'd255,    16'd255,    1'b0};
    vecs[8]  = '{16'd40000,  16'd123,    16'd325,    16'd25,     1'b0};
    vecs[9]  = '{16'd0,      16'd0,      16'hFFFF,   16'd0,      1'b1};
    vecs[10] = '{16'd12345,  16'd1,      16'd12345,  16'd0,      1'b0};

    dif.en = 1'b1;
    dif.start = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;

    #3;
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_q", 32'(dif.quotient), 32'd0);
    chk("rst_r", 32'(dif.remainder), 32'd0);
    chk("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat, bcnt, q, r, z, dna, bza);
      chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("v%0d_r", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i), 32'(z), 32'(vecs[i].z));
      chk($sformatf("v%0d_lat", i), 32'(lat), vecs[i].z ? 32'd1 : 32'(W+1));
      chk($sformatf("v%0d_busycnt", i), 32'(bcnt), vecs[i].z ? 32'd1 : 32'(W+1));
      chk($sformatf("v%0d_done_fall", i), 32'(dna), 32'd0);
      chk($sformatf("v%0d_busy_fall", i), 32'(bza), 32'd0);
    end

    // Stall: en low for 5 edges mid-divide and 2 edges while done is high.
    dif.dividend = 16'd1000;
    dif.divisor  = 16'd3;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    lat = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      lat++;
    end
    dif.en = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("stall_busy", 32'(dif.busy), 32'd1);
    chk("stall_nodone", 32'(dif.done), 32'd0);
    dif.en = 1'b1;
    while (!dif.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("stall_lat", 32'(lat), 32'(W + 1 + 5));
    dif.en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_done_hold%0d", k), 32'(dif.done), 32'd1);
    end
    dif.en = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_done_fall", 32'(dif.done), 32'd0);
    chk("stall_q", 32'(dif.quotient), 32'd333);
    chk("stall_r", 32'(dif.remainder), 32'd1);
    @(posedge clk);
    #1;

    // A start pulse during CALC must not disturb the running divide or queue a second one.
    dif.dividend = 16'd200;
    dif.divisor  = 16'd9;
    dif.start    = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      dif.start = (k == 4);
      if (k == 4) begin
        dif.dividend = 16'd50;
        dif.divisor  = 16'd5;
      end
      if (dif.done) begin
        nd++;
        q = dif.quotient;
        r = dif.remainder;
      end
    end
    chk("ign_pulses", 32'(nd), 32'd1);
    chk("ign_q", 32'(q), 32'd22);
    chk("ign_r", 32'(r), 32'd2);
    chk("ign_idle", 32'(dif.busy), 32'd0);

    // Asynchronous reset between edges in the middle of a divide.
    dif.dividend = 16'd1000;
    dif.divisor  = 16'd7;
    dif.start    = 1'b1;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(dif.busy), 32'd0);
    chk("arst_done", 32'(dif.done), 32'd0);
    chk("arst_q", 32'(dif.quotient), 32'd0);
    chk("arst_r", 32'(dif.remainder), 32'd0);
    chk("arst_dbz", 32'(dif.div_by_zero), 32'd0);
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (dif.done) nd++;
    end
    chk("arst_nodone", 32'(nd), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_div(16'd1000, 16'd7, lat, bcnt, q, r, z, dna, bza);
    chk("post_rst_q", 32'(q), 32'd142);
    chk("post_rst_r", 32'(r), 32'd6);
    chk("post_rst_lat", 32'(lat), 32'(W + 1));

    // Randomised operands, both orders, back-to-back at the earliest start.
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'($urandom_range(0, 15));
        1:       b = 16'($urandom_range(1, 255));
        default: b = 16'($urandom);
      endcase
      for (int o = 0; o < 2; o++) begin
        logic [W-1:0] x, y;
        x = (o == 0) ? a : b;
        y = (o == 0) ? b : a;
        run_div(x, y, lat, bcnt, q, r, z, dna, bza);
        if (y == '0) begin
          chk($sformatf("rnd%0d_%0d_zq", i, o), 32'(q), 32'hFFFF);
          chk($sformatf("rnd%0d_%0d_zr", i, o), 32'(r), 32'(x));
          chk($sformatf("rnd%0d_%0d_zflag", i, o), 32'(z), 32'd1);
        end else begin
          prod = 32'(q) * 32'(y) + 32'(r);
          chk($sformatf("rnd%0d_%0d_inv", i, o), prod, 32'(x));
          chk($sformatf("rnd%0d_%0d_rlt", i, o), 32'(r < y), 32'd1);
          chk($sformatf("rnd%0d_%0d_flag", i, o), 32'(z), 32'd0);
          chk($sformatf("rnd%0d_%0d_lat", i, o), 32'(lat), 32'(W + 1));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
